// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath mux encodings and the bundled control-output struct.
package multicycle_control_unit_pkg;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [4:0] {
      S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
      S_LUI, S_AUIPC, S_TRAP
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;
   localparam logic [1:0] SRCA_ZERO  = 2'd3;

   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_IMM   = 2'd1;
   localparam logic [1:0] SRCB_FOUR  = 2'd2;

   localparam logic [1:0] ALUOP_ADD  = 2'd0;
   localparam logic [1:0] ALUOP_SUB  = 2'd1;
   localparam logic [1:0] ALUOP_FUNC = 2'd2;

   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       trap;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_control_out_decoder.sv
// Combinational map from FSM state (plus the two Mealy inputs) to datapath controls.
module multicycle_control_unit_control_out_decoder
   import multicycle_control_unit_pkg::*;
(
   input  state_t state_i,
   input  logic   mem_ready_i,
   input  logic   branch_taken_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req    = 1'b1;
            ctrl_o.adr_src    = 1'b0;
            ctrl_o.alu_src_a  = SRCA_PC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALU;
            // PC+4 and the IR load commit only on the cycle the fetch completes
            ctrl_o.ir_write   = mem_ready_i;
            ctrl_o.pc_write   = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_a = SRCA_OLDPC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.result_src = RES_MEM;
            ctrl_o.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.mem_we  = 1'b1;
            ctrl_o.adr_src = 1'b1;
         end
         S_EXECR: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.alu_op    = ALUOP_FUNC;
         end
         S_EXECI: begin
            ctrl_o.alu_src_a = SRCA_RS1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_FUNC;
         end
         S_LUI: begin
            ctrl_o.alu_src_a = SRCA_ZERO;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_AUIPC: begin
            ctrl_o.alu_src_a = SRCA_OLDPC;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_ALUWB: begin
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a  = SRCA_RS1;
            ctrl_o.alu_src_b  = SRCB_RS2;
            ctrl_o.alu_op     = ALUOP_SUB;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.pc_write   = branch_taken_i;
         end
         S_JAL: begin
            // PC takes the DECODE target from ALUOut while the ALU forms oldPC+4
            ctrl_o.alu_src_a  = SRCA_OLDPC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALUOUT;
            ctrl_o.pc_write   = 1'b1;
         end
         S_JALR: begin
            ctrl_o.alu_src_a  = SRCA_RS1;
            ctrl_o.alu_src_b  = SRCB_IMM;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALU;
            ctrl_o.pc_write   = 1'b1;
         end
         S_JALR_LINK: begin
            ctrl_o.alu_src_a  = SRCA_OLDPC;
            ctrl_o.alu_src_b  = SRCB_FOUR;
            ctrl_o.alu_op     = ALUOP_ADD;
            ctrl_o.result_src = RES_ALU;
            ctrl_o.reg_write  = 1'b1;
         end
         S_TRAP: ctrl_o.trap = 1'b1;
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and halts in TRAP on an unsupported opcode.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode_i,
   input  logic             branch_taken_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             adr_src_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       result_src_o,
   output logic [CNT_W-1:0] instr_count_o,
   output logic             trap_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             retire;
   ctrl_t            ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RESET;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_RESET:    state_d = S_FETCH;
         S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_IMM:       state_d = S_EXECI;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR;
               OP_LUI:       state_d = S_LUI;
               OP_AUIPC:     state_d = S_AUIPC;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (opcode_i == OP_LW)      state_d = S_MEMREAD;
            else if (opcode_i == OP_SW) state_d = S_MEMWRITE;
            else                        state_d = S_TRAP;
         end
         S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready_i) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
         S_JALR:     state_d = S_JALR_LINK;
         S_ALUWB, S_BRANCH, S_JALR_LINK: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_RESET;
      endcase
      count_d = count_q + CNT_W'(retire);
   end

   // Outputs decode from state_q, so an async rst zeroes them (including mem_req) at once.
   multicycle_control_unit_control_out_decoder control_out_decoder (
      .state_i        (state_q),
      .mem_ready_i    (mem_ready_i),
      .branch_taken_i (branch_taken_i),
      .ctrl_o         (ctrl)
   );

   assign mem_req_o     = ctrl.mem_req;
   assign mem_we_o      = ctrl.mem_we;
   assign adr_src_o     = ctrl.adr_src;
   assign ir_write_o    = ctrl.ir_write;
   assign pc_write_o    = ctrl.pc_write;
   assign reg_write_o   = ctrl.reg_write;
   assign alu_src_a_o   = ctrl.alu_src_a;
   assign alu_src_b_o   = ctrl.alu_src_b;
   assign alu_op_o      = ctrl.alu_op;
   assign result_src_o  = ctrl.result_src;
   assign trap_o        = ctrl.trap;
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle vectors for the multi-cycle control FSM; the counter is
// built 3 bits wide so the table also crosses the wrap point.
module tb_multicycle_control_unit;

   localparam int TB_CNT_W = 3;

   localparam logic [6:0] T_LW    = 7'b0000011;
   localparam logic [6:0] T_SW    = 7'b0100011;
   localparam logic [6:0] T_R     = 7'b0110011;
   localparam logic [6:0] T_IMM   = 7'b0010011;
   localparam logic [6:0] T_BR    = 7'b1100011;
   localparam logic [6:0] T_JAL   = 7'b1101111;
   localparam logic [6:0] T_JALR  = 7'b1100111;
   localparam logic [6:0] T_LUI   = 7'b0110111;
   localparam logic [6:0] T_AUIPC = 7'b0010111;
   localparam logic [6:0] T_BAD   = 7'b1111111;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [6:0]          opcode_i = '0;
   logic                branch_taken_i = 1'b0;
   logic                mem_ready_i = 1'b1;
   logic                mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o, trap_o;
   logic [1:0]          alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
   logic [TB_CNT_W-1:0] instr_count_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.CNT_W(TB_CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode_i       (opcode_i),
      .branch_taken_i (branch_taken_i),
      .mem_ready_i    (mem_ready_i),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .adr_src_o      (adr_src_o),
      .ir_write_o     (ir_write_o),
      .pc_write_o     (pc_write_o),
      .reg_write_o    (reg_write_o),
      .alu_src_a_o    (alu_src_a_o),
      .alu_src_b_o    (alu_src_b_o),
      .alu_op_o       (alu_op_o),
      .result_src_o   (result_src_o),
      .instr_count_o  (instr_count_o),
      .trap_o         (trap_o)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic [6:0]  op;
      logic        br;
      logic        rdy;
      logic [14:0] exp;
      int          cnt;
   } vec_t;

   vec_t vecs[$];

   // {req, we, adr, irw, pcw, rw, a, b, op, rs, trap}
   function automatic logic [14:0] o(input logic req, we, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, op, rs, input logic trap);
      return {req, we, adr, irw, pcw, rw, a, b, op, rs, trap};
   endfunction

   task automatic add(input string nm, input logic r, input logic [6:0] op,
                      input logic br, input logic rdy, input logic [14:0] exp, input int cnt);
      vec_t v;
      v.name = nm; v.rst = r; v.op = op; v.br = br; v.rdy = rdy; v.exp = exp; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic [6:0] op, input logic br, input logic rdy);
      @(negedge clk);
      rst = r; opcode_i = op; branch_taken_i = br; mem_ready_i = rdy;
      #1;
   endtask

   task automatic check(input string nm, input logic [14:0] exp, input int cnt);
      logic [14:0]         act;
      logic [TB_CNT_W-1:0] ecnt;
      act  = {mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
              alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, trap_o};
      ecnt = TB_CNT_W'(cnt);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s outputs: got %b want %b", nm, act, exp);
      end
      n_cmp++;
      if (instr_count_o !== ecnt) begin
         n_bad++;
         $display("FAIL %s count: got %0d want %0d", nm, instr_count_o, ecnt);
      end
   endtask

   initial begin
      logic [14:0] e_z, e_f1, e_f0, e_dec, e_madr, e_mrd, e_mwb, e_mwr, e_exr, e_exi;
      logic [14:0] e_lui, e_aui, e_awb, e_br1, e_br0, e_jal, e_jalr, e_jlnk, e_trap;
      e_z    = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0);
      e_f1   = o(1,0,0,1,1,0, 2'd0,2'd2,2'd0,2'd2, 0);
      e_f0   = o(1,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2, 0);
      e_dec  = o(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0);
      e_madr = o(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0);
      e_mrd  = o(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0);
      e_mwb  = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 0);
      e_mwr  = o(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0);
      e_exr  = o(0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0, 0);
      e_exi  = o(0,0,0,0,0,0, 2'd2,2'd1,2'd2,2'd0, 0);
      e_lui  = o(0,0,0,0,0,0, 2'd3,2'd1,2'd0,2'd0, 0);
      e_aui  = o(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0);
      e_awb  = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0);
      e_br1  = o(0,0,0,0,1,0, 2'd2,2'd0,2'd1,2'd0, 0);
      e_br0  = o(0,0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0, 0);
      e_jal  = o(0,0,0,0,1,0, 2'd1,2'd2,2'd0,2'd0, 0);
      e_jalr = o(0,0,0,0,1,0, 2'd2,2'd1,2'd0,2'd2, 0);
      e_jlnk = o(0,0,0,0,0,1, 2'd1,2'd2,2'd0,2'd2, 0);
      e_trap = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1);

      add("rst_held",    1, T_IMM, 0, 1, e_z,    0);
      add("reset_state", 0, T_IMM, 0, 1, e_z,    0);
      add("addi_fetch",  0, T_IMM, 0, 1, e_f1,   0);
      add("addi_dec",    0, T_IMM, 0, 0, e_dec,  0);
      add("addi_execi",  0, T_IMM, 0, 0, e_exi,  0);
      add("addi_aluwb",  0, T_IMM, 0, 1, e_awb,  0);
      add("lw_fetch",    0, T_LW,  0, 1, e_f1,   1);
      add("lw_dec",      0, T_LW,  0, 1, e_dec,  1);
      add("lw_madr",     0, T_LW,  0, 1, e_madr, 1);
      add("lw_wait0",    0, T_LW,  0, 0, e_mrd,  1);
      add("lw_wait1",    0, T_LW,  0, 0, e_mrd,  1);
      add("lw_wait2",    0, T_LW,  0, 0, e_mrd,  1);
      add("lw_rdy",      0, T_LW,  0, 1, e_mrd,  1);
      add("lw_memwb",    0, T_LW,  0, 0, e_mwb,  1);
      add("beqt_fetch",  0, T_BR,  1, 1, e_f1,   2);
      add("beqt_dec",    0, T_BR,  1, 1, e_dec,  2);
      add("beqt_branch", 0, T_BR,  1, 0, e_br1,  2);
      add("beqn_fetch",  0, T_BR,  0, 1, e_f1,   3);
      add("beqn_dec",    0, T_BR,  0, 1, e_dec,  3);
      add("beqn_branch", 0, T_BR,  0, 1, e_br0,  3);
      add("jalr_fetch",  0, T_JALR,0, 1, e_f1,   4);
      add("jalr_dec",    0, T_JALR,0, 1, e_dec,  4);
      add("jalr_jalr",   0, T_JALR,0, 1, e_jalr, 4);
      add("jalr_link",   0, T_JALR,0, 1, e_jlnk, 4);
      add("sw_fetchw",   0, T_SW,  0, 0, e_f0,   5);
      add("sw_fetch",    0, T_SW,  0, 1, e_f1,   5);
      add("sw_dec",      0, T_SW,  0, 1, e_dec,  5);
      add("sw_madr",     0, T_SW,  0, 1, e_madr, 5);
      add("sw_wait",     0, T_SW,  0, 0, e_mwr,  5);
      add("sw_rdy",      0, T_SW,  0, 1, e_mwr,  5);
      add("jal_fetch",   0, T_JAL, 0, 1, e_f1,   6);
      add("jal_dec",     0, T_JAL, 0, 1, e_dec,  6);
      add("jal_jal",     0, T_JAL, 0, 1, e_jal,  6);
      add("jal_aluwb",   0, T_JAL, 0, 1, e_awb,  6);
      add("r_fetch",     0, T_R,   0, 1, e_f1,   7);
      add("r_dec",       0, T_R,   0, 1, e_dec,  7);
      add("r_execr",     0, T_R,   0, 1, e_exr,  7);
      add("r_aluwb",     0, T_R,   0, 1, e_awb,  7);
      add("lui_fetch",   0, T_LUI, 0, 1, e_f1,   8);
      add("lui_dec",     0, T_LUI, 0, 1, e_dec,  8);
      add("lui_lui",     0, T_LUI, 0, 1, e_lui,  8);
      add("lui_aluwb",   0, T_LUI, 0, 1, e_awb,  8);
      add("aui_fetch",   0, T_AUIPC,0,1, e_f1,   9);
      add("aui_dec",     0, T_AUIPC,0,1, e_dec,  9);
      add("aui_auipc",   0, T_AUIPC,0,1, e_aui,  9);
      add("aui_aluwb",   0, T_AUIPC,0,1, e_awb,  9);
      add("bad_fetch",   0, T_BAD, 0, 1, e_f1,   10);
      add("bad_dec",     0, T_BAD, 0, 1, e_dec,  10);
      add("bad_trap0",   0, T_BAD, 0, 1, e_trap, 10);
      add("bad_trap1",   0, T_IMM, 1, 1, e_trap, 10);
      add("bad_trap2",   0, T_LW,  0, 0, e_trap, 10);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].op, vecs[i].br, vecs[i].rdy);
         check(vecs[i].name, vecs[i].exp, vecs[i].cnt);
      end

      // Reset clears the trap, then a store is aborted by rst while waiting for memory.
      drive(1, T_IMM, 0, 1); check("rst2_held", e_z, 0);
      drive(0, T_IMM, 0, 1); check("rst2_state", e_z, 0);
      drive(0, T_IMM, 0, 1); check("rst2_addi_f", e_f1, 0);
      drive(0, T_IMM, 0, 1); check("rst2_addi_d", e_dec, 0);
      drive(0, T_IMM, 0, 1); check("rst2_addi_x", e_exi, 0);
      drive(0, T_IMM, 0, 1); check("rst2_addi_wb", e_awb, 0);
      drive(0, T_SW,  0, 1); check("abort_fetch", e_f1, 1);
      drive(0, T_SW,  0, 1); check("abort_dec", e_dec, 1);
      drive(0, T_SW,  0, 1); check("abort_madr", e_madr, 1);
      drive(0, T_SW,  0, 0); check("abort_wait0", e_mwr, 1);
      drive(0, T_SW,  0, 0); check("abort_wait1", e_mwr, 1);
      // rst rises mid-cycle with ready low; request must vanish before the next edge.
      drive(1, T_SW,  0, 0); check("abort_rst", e_z, 0);
      drive(1, T_SW,  0, 1); check("abort_rst_hold", e_z, 0);
      drive(0, T_SW,  0, 1); check("abort_release", e_z, 0);
      drive(0, T_JALR,0, 1); check("post_fetch", e_f1, 0);
      drive(0, T_JALR,0, 1); check("post_dec", e_dec, 0);
      drive(0, T_JALR,0, 1); check("post_jalr", e_jalr, 0);
      drive(0, T_JALR,0, 1); check("post_link", e_jlnk, 0);
      drive(0, T_JALR,0, 1); check("post_count", e_f1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
